// File: rtl/clock_time_counter.sv
// Digital clock timekeeping: 1 Hz prescaler, BCD HH:MM:SS and a two-button time-set FSM.
// Define CLOCK_12H_EN to show hours in 12-hour form with a PM flag (internal time stays 24 h).
module clock_time_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int PRESC_W  = 27
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] in1,
    output logic [3:0] in2,
    output logic [3:0] in3,
    output logic [3:0] in4,
    output logic [7:0] sec_bcd,
    output logic       sec_tick,
    output logic [1:0] mode,
    output logic       pm
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_e;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    mode_e              state_q, state_d;
    logic               mode_prev_q, inc_prev_q;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [3:0]         sec_t_q, sec_u_q, min_t_q, min_u_q, hr_t_q, hr_u_q;
    logic [3:0]         sec_t_d, sec_u_d, min_t_d, min_u_d, hr_t_d, hr_u_d;

    logic mode_press, inc_press;
    logic in_run, restart, inc_hr, inc_min;
    logic sec_step, sec_carry, min_step, min_carry, hr_step;

    assign mode_press = btn_mode & ~mode_prev_q;
    assign inc_press  = btn_inc & ~inc_prev_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            case (state_q)
                RUN:     state_d = SET_HR;
                SET_HR:  state_d = SET_MIN;
                default: state_d = RUN;
            endcase
        end
    end

    // A mode press always wins over an inc press on the same edge.
    always_comb begin
        in_run  = (state_q == RUN);
        restart = mode_press & ((state_q == RUN) | (state_q == SET_MIN));
        inc_hr  = inc_press & ~mode_press & (state_q == SET_HR);
        inc_min = inc_press & ~mode_press & (state_q == SET_MIN);
        mode    = state_q;
    end

    assign sec_step  = in_run & tick_q & ~mode_press;
    assign sec_carry = sec_step & (sec_t_q == 4'd5) & (sec_u_q == 4'd9);
    assign min_step  = sec_carry | inc_min;
    assign min_carry = sec_carry & (min_t_q == 4'd5) & (min_u_q == 4'd9);
    assign hr_step   = min_carry | inc_hr;

    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        sec_t_d = sec_t_q;
        sec_u_d = sec_u_q;
        min_t_d = min_t_q;
        min_u_d = min_u_q;
        hr_t_d  = hr_t_q;
        hr_u_d  = hr_u_q;

        if (restart) begin
            presc_d = '0;
        end else if (in_run) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end

        if (restart) begin
            sec_t_d = 4'd0;
            sec_u_d = 4'd0;
        end else if (sec_step) begin
            if (sec_u_q != 4'd9) begin
                sec_u_d = sec_u_q + 4'd1;
            end else begin
                sec_u_d = 4'd0;
                sec_t_d = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
            end
        end

        if (min_step) begin
            if (min_u_q != 4'd9) begin
                min_u_d = min_u_q + 4'd1;
            end else begin
                min_u_d = 4'd0;
                min_t_d = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
            end
        end

        if (hr_step) begin
            if ((hr_t_q == 4'd2) && (hr_u_q == 4'd3)) begin
                hr_t_d = 4'd0;
                hr_u_d = 4'd0;
            end else if (hr_u_q == 4'd9) begin
                hr_t_d = hr_t_q + 4'd1;
                hr_u_d = 4'd0;
            end else begin
                hr_u_d = hr_u_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            sec_t_q     <= 4'd0;
            sec_u_q     <= 4'd0;
            min_t_q     <= 4'd0;
            min_u_q     <= 4'd0;
            hr_t_q      <= 4'd0;
            hr_u_q      <= 4'd0;
        end else begin
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            sec_t_q     <= sec_t_d;
            sec_u_q     <= sec_u_d;
            min_t_q     <= min_t_d;
            min_u_q     <= min_u_d;
            hr_t_q      <= hr_t_d;
            hr_u_q      <= hr_u_d;
        end
    end

    assign in3      = min_t_q;
    assign in4      = min_u_q;
    assign sec_bcd  = {sec_t_q, sec_u_q};
    assign sec_tick = tick_q;

`ifdef CLOCK_12H_EN
    // Display digits are derived from next-state hours so they change on the same edge.
    logic [4:0] hr_bin, hr12;
    logic [3:0] disp_t_d, disp_u_d, disp_t_q, disp_u_q;
    logic       pm_d, pm_q;

    always_comb begin
        hr_bin = 5'(hr_t_d) * 5'd10 + 5'(hr_u_d);
        if (hr_bin == 5'd0) begin
            hr12 = 5'd12;
        end else if (hr_bin > 5'd12) begin
            hr12 = hr_bin - 5'd12;
        end else begin
            hr12 = hr_bin;
        end
        disp_t_d = (hr12 >= 5'd10) ? 4'd1 : 4'd0;
        disp_u_d = (hr12 >= 5'd10) ? 4'(hr12 - 5'd10) : 4'(hr12);
        pm_d     = (hr_bin >= 5'd12);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            disp_t_q <= 4'd0;
            disp_u_q <= 4'd0;
            pm_q     <= 1'b0;
        end else begin
            disp_t_q <= disp_t_d;
            disp_u_q <= disp_u_d;
            pm_q     <= pm_d;
        end
    end

    assign in1 = disp_t_q;
    assign in2 = disp_u_q;
    assign pm  = pm_q;
`else
    assign in1 = hr_t_q;
    assign in2 = hr_u_q;
    assign pm  = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: hand-written vector table, corner sequences and a
// randomized run checked against a seconds-of-day reference model.
module tb_clock_time_counter;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       clr, btn_mode, btn_inc;
    logic [3:0] in1, in2, in3, in4;
    logic [7:0] sec_bcd;
    logic       sec_tick;
    logic [1:0] mode;
    logic       pm;

    always #5 clk = ~clk;

    clock_time_counter #(.TICK_DIV(TD), .PRESC_W(3)) dut (
        .clk(clk), .clr(clr), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .sec_bcd(sec_bcd), .sec_tick(sec_tick), .mode(mode), .pm(pm)
    );

    typedef struct {
        bit c;
        bit m;
        bit i;
        int e_mode;
        int e_tick;
        int e_hr;
        int e_min;
        int e_sec;
    } vec_t;

    vec_t vq[$];

    int n_pass  = 0;
    int n_total = 0;
    bit model_chk = 1'b0;

    // Reference model: time as seconds of day, tick phase from the cycle of the last restart.
    int m_cyc  = 0;
    int m_mode = 0;
    int m_tod  = 0;
    int m_t0   = 0;
    bit m_tick = 1'b0;
    bit m_mprev = 1'b0;
    bit m_iprev = 1'b0;
    bit m_rst  = 1'b0;

    function automatic void check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic int disp_hr(int h);
`ifdef CLOCK_12H_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
`else
        return h;
`endif
    endfunction

    function automatic int disp_pm(int h);
`ifdef CLOCK_12H_EN
        return (h >= 12) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_hh(int h);
        int d;
        d = disp_hr(h);
        return (d / 10) * 16 + (d % 10);
    endfunction

    function automatic int bcd2(int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic void add(bit c, bit m, bit i, int md, int tk, int hr, int mn, int sc);
        vec_t v;
        v.c = c; v.m = m; v.i = i;
        v.e_mode = md; v.e_tick = tk; v.e_hr = hr; v.e_min = mn; v.e_sec = sc;
        vq.push_back(v);
    endfunction

    function automatic void model_edge(bit c, bit m, bit i);
        bit mp, ip, nt;
        int h, mn;
        m_cyc++;
        if (c) begin
            m_mode = 0; m_tod = 0; m_t0 = m_cyc; m_tick = 0;
            m_mprev = 0; m_iprev = 0; m_rst = 1;
        end else begin
            mp = m && !m_mprev;
            ip = i && !m_iprev;
            nt = 0;
            if (mp) begin
                if (m_mode == 0) begin
                    m_mode = 1;
                    m_tod  = m_tod - (m_tod % 60);
                end else if (m_mode == 1) begin
                    m_mode = 2;
                end else begin
                    m_mode = 0;
                    m_tod  = m_tod - (m_tod % 60);
                    m_t0   = m_cyc;
                end
            end else if (m_mode == 0) begin
                if (m_tick) m_tod = (m_tod + 1) % 86400;
                if (m_cyc != m_t0 && ((m_cyc - m_t0) % TD) == 0) nt = 1;
            end else if (m_mode == 1 && ip) begin
                h = (m_tod / 3600 + 1) % 24;
                m_tod = h * 3600 + (m_tod % 3600);
            end else if (m_mode == 2 && ip) begin
                mn = ((m_tod / 60) % 60 + 1) % 60;
                m_tod = (m_tod / 3600) * 3600 + mn * 60 + (m_tod % 60);
            end
            m_tick  = nt;
            m_mprev = m;
            m_iprev = i;
            m_rst   = 0;
        end
    endfunction

    task automatic compare_model();
        int h, dh, mn, sc;
        h  = m_tod / 3600;
        mn = (m_tod / 60) % 60;
        sc = m_tod % 60;
        dh = m_rst ? 0 : disp_hr(h);
        check("model in1", int'(in1), dh / 10);
        check("model in2", int'(in2), dh % 10);
        check("model in3", int'(in3), mn / 10);
        check("model in4", int'(in4), mn % 10);
        check("model sec_bcd", int'(sec_bcd), bcd2(sc));
        check("model sec_tick", int'(sec_tick), int'(m_tick));
        check("model mode", int'(mode), m_mode);
        check("model pm", int'(pm), m_rst ? 0 : disp_pm(h));
    endtask

    task automatic step(bit c, bit m, bit i);
        clr = c; btn_mode = m; btn_inc = i;
        @(posedge clk);
        model_edge(c, m, i);
        #1;
        if (model_chk) compare_model();
    endtask

    task automatic press_mode();
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    task automatic press_inc();
        step(0, 0, 1);
        step(0, 0, 0);
    endtask

`ifdef CLOCK_12H_EN
    localparam int H00 = 8'h12, H12 = 8'h12, H13 = 8'h01;
    localparam int P00 = 0, P12 = 1, P13 = 1;
`else
    localparam int H00 = 8'h00, H12 = 8'h12, H13 = 8'h13;
    localparam int P00 = 0, P12 = 0, P13 = 0;
`endif

    initial begin
        int ticks, dbl, dh, hhmm;
        bit prevt;
        bit rc, rm, ri;
        clr = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;

        //   c  m  i   mode tick hr min sec
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 1, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 1);
        add(0, 0, 0,   0, 0, 0, 0, 1);
        add(0, 0, 0,   0, 0, 0, 0, 1);
        add(0, 0, 0,   0, 1, 0, 0, 1);
        add(0, 0, 0,   0, 0, 0, 0, 2);
        add(0, 1, 0,   1, 0, 0, 0, 0);
        add(0, 1, 1,   1, 0, 1, 0, 0);
        add(0, 0, 1,   1, 0, 1, 0, 0);
        add(0, 0, 0,   1, 0, 1, 0, 0);
        add(0, 1, 1,   2, 0, 1, 0, 0);
        add(0, 0, 0,   2, 0, 1, 0, 0);
        add(0, 0, 1,   2, 0, 1, 1, 0);
        add(0, 0, 1,   2, 0, 1, 1, 0);
        add(0, 1, 0,   0, 0, 1, 1, 0);
        add(0, 0, 0,   0, 0, 1, 1, 0);
        add(0, 0, 0,   0, 0, 1, 1, 0);
        add(0, 0, 0,   0, 0, 1, 1, 0);
        add(0, 0, 0,   0, 1, 1, 1, 0);
        add(0, 0, 0,   0, 0, 1, 1, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 1, 0, 0, 0);
        add(0, 1, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1,   1, 0, 1, 0, 0);
        add(1, 0, 1,   0, 0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);

        foreach (vq[k]) begin
            step(vq[k].c, vq[k].m, vq[k].i);
            dh   = vq[k].c ? 0 : disp_hr(vq[k].e_hr);
            hhmm = (dh / 10) * 4096 + (dh % 10) * 256 + bcd2(vq[k].e_min);
            check($sformatf("vec%0d mode", k), int'(mode), vq[k].e_mode);
            check($sformatf("vec%0d tick", k), int'(sec_tick), vq[k].e_tick);
            check($sformatf("vec%0d hhmm", k), int'({in1, in2, in3, in4}), hhmm);
            check($sformatf("vec%0d sec", k), int'(sec_bcd), bcd2(vq[k].e_sec));
            check($sformatf("vec%0d pm", k), int'(pm), vq[k].c ? 0 : disp_pm(vq[k].e_hr));
        end

        model_chk = 1'b1;

        // One minute of ticks from reset.
        step(1, 0, 0);
        ticks = 0; dbl = 0; prevt = 1'b0;
        repeat (241) begin
            step(0, 0, 0);
            if (sec_tick) ticks++;
            if (sec_tick && prevt) dbl++;
            prevt = sec_tick;
        end
        check("tick count 60s", ticks, 60);
        check("tick wider than one cycle", dbl, 0);
        check("minutes after 60 ticks", int'({in3, in4}), 8'h01);
        check("seconds after 60 ticks", int'(sec_bcd), 8'h00);

        // Hour and minute wrap while setting.
        step(1, 0, 0);
        press_mode();
        repeat (25) press_inc();
        check("set_hr mode", int'(mode), 1);
        check("hours after 25 inc", int'({in1, in2}), exp_hh(1));
        press_mode();
        repeat (61) press_inc();
        check("set_min mode", int'(mode), 2);
        check("minutes after 61 inc", int'({in3, in4}), 8'h01);
        check("hours kept in set_min", int'({in1, in2}), exp_hh(1));
        press_mode();
        check("back to run", int'(mode), 0);
        check("seconds on leaving set", int'(sec_bcd), 8'h00);

        // Simultaneous presses, then a long inc hold.
        step(1, 0, 0);
        press_mode();
        press_inc();
        press_inc();
        step(0, 1, 1);
        check("simultaneous mode", int'(mode), 2);
        check("simultaneous hours", int'({in1, in2}), exp_hh(2));
        check("simultaneous minutes", int'({in3, in4}), 8'h00);
        step(0, 0, 0);
        repeat (100) step(0, 0, 1);
        check("held inc minutes", int'({in3, in4}), 8'h01);
        step(0, 0, 0);
        check("held inc release", int'({in3, in4}), 8'h01);

        // Midnight rollover from 23:59:59.
        step(1, 0, 0);
        press_mode();
        repeat (23) press_inc();
        press_mode();
        repeat (59) press_inc();
        press_mode();
        repeat (239) step(0, 0, 0);
        check("pre-rollover hours", int'({in1, in2}), exp_hh(23));
        check("pre-rollover minutes", int'({in3, in4}), 8'h59);
        check("pre-rollover seconds", int'(sec_bcd), 8'h59);
        check("pre-rollover tick", int'(sec_tick), 1);
        step(0, 0, 0);
        check("rollover hours", int'({in1, in2}), exp_hh(0));
        check("rollover minutes", int'({in3, in4}), 8'h00);
        check("rollover seconds", int'(sec_bcd), 8'h00);

        // Hour display format at 00, 12 and 13.
        step(1, 0, 0);
        press_mode();
        check("disp hour 00", int'({in1, in2}), H00);
        check("pm hour 00", int'(pm), P00);
        repeat (12) press_inc();
        check("disp hour 12", int'({in1, in2}), H12);
        check("pm hour 12", int'(pm), P12);
        press_inc();
        check("disp hour 13", int'({in1, in2}), H13);
        check("pm hour 13", int'(pm), P13);

        // Randomized buttons with occasional clears.
        step(1, 0, 0);
        repeat (3000) begin
            rc = ($urandom_range(0, 599) == 0);
            rm = ($urandom_range(0, 39) == 0);
            ri = ($urandom_range(0, 2) == 0);
            step(rc, rm, ri);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
- Timekeeping stage of the digital clock. Divides the board clock down to a 1 Hz tick and keeps hours, minutes and seconds in BCD.
- Handles a two-button time-set state machine.
- Drives the four BCD digits (HH:MM) consumed directly by the seven-segment display driver.

Parameters:
- TICK_DIV, 100000000, clk cycles per second tick (set small, e.g. 4, in simulation).
- PRESC_W, 27, prescaler counter width; must satisfy 2^PRESC_W >= TICK_DIV.

Ports:
- clk  input  1  system clock
- clr  input  1  synchronous active-high reset
- btn_mode  input  1  mode button, debounced and synchronous upstream, level
- btn_inc  input  1  increment button, debounced and synchronous upstream, level
- in1  output  4  hours tens BCD (display left)
- in2  output  4  hours units BCD
- in3  output  4  minutes tens BCD
- in4  output  4  minutes units BCD (display right)
- sec_bcd  output  8  seconds, {tens, units} BCD
- sec_tick  output  1  one-cycle pulse per second (drives colon blink)
- mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN
- pm  output  1  PM indicator (CLOCK_12H_EN only; tied 0 otherwise)

Behaviour:
- Reset (clr=1 at posedge clk, synchronous) sets:
  - prescaler=0, time=00:00:00 (in1..in4=0, sec_bcd=8'h00)
  - sec_tick=0, mode=RUN, pm=0
  - button history registers=0
- clr has priority over every other event, including mid-set or mid-carry.
- Button edges:
  - btn_*_prev registered each cycle.
  - Press = btn & ~btn_prev, acted on at the same edge it is detected.
  - Holding a button gives exactly one event.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and wraps.
  - sec_tick is a registered pulse, high for the one cycle following the edge at which the prescaler wrapped, so the period is exactly TICK_DIV cycles.
  - First sec_tick after reset or after leaving SET_MIN arrives TICK_DIV cycles later.
- RUN:
  - The time register advances on the edge that samples sec_tick=1, so digits change one cycle after sec_tick rises.
  - Seconds 59->00 carries to minutes; minutes 59->00 carries to hours; hours 23->00.
  - 23:59:59 -> 00:00:00 in a single edge.
  - Each BCD digit is always 0-9; tens digits are never above 5 (min/sec) or 2 (hr).
- FSM (mode press): RUN -> SET_HR -> SET_MIN -> RUN.
  - Entering SET_HR: prescaler=0, seconds=00, sec_tick forced 0 while not RUN.
  - Leaving SET_MIN: prescaler=0, seconds=00.
- SET_HR: each inc press increments hours 00..23 and wraps to 00; minutes unaffected.
- SET_MIN: each inc press increments minutes 00..59 and wraps to 00; no carry into hours.
- inc press in RUN is ignored.
- Simultaneous mode and inc press: mode transition wins, inc is discarded.
- All outputs are registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CLOCK_12H_EN.
- Defined:
  - Internal time stays 24 h; in1/in2 show 12-hour format: 00->12, 01..12 unchanged, 13..23->01..11.
  - pm=1 for internal hours 12..23, else 0. pm updates on the same edge as the digits.
  - SET_HR increments the internal 24 h value, so the display sequence is 12,01..11 (pm=0), then 12,01..11 (pm=1).
- Undefined: in1/in2 show 24-hour BCD; pm tied 0.

Test Plan:
- clr pulse mid-count with TICK_DIV=4 -> next cycle in1..in4=0, sec_bcd=00, mode=00, sec_tick=0; first sec_tick 4 cycles after clr deasserts.
- Run 4*60 cycles from reset -> sec_tick pulsed 60 times, each one cycle wide; in3:in4=01, sec_bcd=00.
- Preset 23:59:59 via set mode plus 59 ticks, then one tick -> all digits 0 on one edge, no intermediate value like 24:00.
- mode press, 25 inc presses -> mode=01, hours=01; mode press, 61 inc presses -> mode=10, minutes=01, hours still 01; mode press -> mode=00, sec_bcd=00.
- btn_mode and btn_inc rise on the same cycle in SET_HR -> mode=10, hours unchanged; btn_inc held 100 cycles in SET_MIN -> minutes +1 only.
- With CLOCK_12H_EN, set hours to 00, 12, 13 -> display 12/pm=0, 12/pm=1, 01/pm=1; without the macro -> 00, 12, 13 and pm=0.
